instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

- Fetch stage of the RV32IM pipeline, directly upstream of the decode stage.
- Owns the PC and issues word reads to instruction memory, tolerating a busywait memory.
- Handles decode stalls with a one-entry skid buffer and redirects on taken branches/jumps from EX.
- Drives the IF/ID register whose `INSTRUCTION` output feeds the control unit and register file.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; low two bits must be 0.
- `CLK` in 1: single clock; all state on rising edge.
- `RESET` in 1: asynchronous, active-low reset; asserted when 0.
- `STALL` in 1: hazard stall from decode; freezes the IF/ID register.
- `BRANCH_TAKEN` in 1: redirect request from EX, valid for one cycle.
- `BRANCH_TARGET` in 32: redirect address; bits [1:0] are ignored and forced to 0.
- `IMEM_ADDR` out 32: fetch address.
- `IMEM_READ` out 1: read request.
- `IMEM_BUSYWAIT` in 1: memory not ready. Data is valid in any cycle with `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0 (an "accept").
- `IMEM_INSTR` in 32: fetched word.
- `INSTRUCTION` out 32: IF/ID instruction.
- `PC_OUT` out 32: IF/ID PC.
- `PC_PLUS4` out 32: IF/ID PC+4, used by JAL/JALR link.
- `VALID` out 1: IF/ID holds a real instruction.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `redirect_pc`.
  - `skid_instr` / `skid_pc`.
  - IF/ID: `INSTRUCTION`, `PC_OUT`, `PC_PLUS4`, `VALID`.
  - 2-bit state.
- Reset values:
  - `pc`=`RESET_PC`; state=FETCH.
  - `INSTRUCTION`=0 (opcode 0 suppresses register and memory writes downstream).
  - `PC_OUT`=0, `PC_PLUS4`=0, `VALID`=0.
  - `IMEM_READ`=0 while `RESET` is low.
- State FETCH: `IMEM_READ`=1, `IMEM_ADDR`=`pc`.
  - Accept with `BRANCH_TAKEN`: discard the word, `pc`←target, stay in FETCH.
  - Accept with `STALL`=0: IF/ID←{word, `pc`, `pc`+4}, `VALID`←1, `pc`←`pc`+4.
  - Accept with `STALL`=1: skid←{word, `pc`}, `pc`←`pc`+4, go to HOLD.
  - Busywait with `BRANCH_TAKEN`: `redirect_pc`←target, go to DRAIN.
- State HOLD: `IMEM_READ`=0.
  - `BRANCH_TAKEN`: drop the skid, `pc`←target, go to FETCH.
  - `STALL`=0: IF/ID←skid, `VALID`←1, go to FETCH.
- State DRAIN: `IMEM_READ`=1 at the old `pc`. An in-flight read is never aborted.
  - On accept: discard the word, `pc`←`redirect_pc`, go to FETCH.
  - A further `BRANCH_TAKEN` overwrites `redirect_pc`.
- IF/ID update priority: `BRANCH_TAKEN` clears `VALID` and sets `INSTRUCTION`←0, then `STALL` holds, then load, else bubble (`VALID`←0, `INSTRUCTION`←0).
- Boundary rules:
  - `BRANCH_TAKEN` has priority over `STALL` in every state.
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
  - At most one outstanding read and one skid entry; no FIFO.
  - Reset asserted mid-read or mid-drain returns to reset values immediately; the pending memory response is ignored.

## Timing
- Zero-wait memory: one instruction per cycle. The first valid IF/ID appears on the 1st rising edge after `RESET` deasserts.
- Fetch latency: memory wait cycles + 1 edge.
- Redirect from FETCH (no busywait): target is fetched in the cycle after `BRANCH_TAKEN`, giving a 1-cycle bubble in IF/ID.
- Redirect in DRAIN: target fetched in the cycle after the drain accept.
- Outputs are registered except `IMEM_READ` and `IMEM_ADDR`, which depend on state and `pc` only and are never combinational from inputs.

## Structure
- Shared package `fetch_pkg` holds:
  - State encodings: FETCH=2'b00, HOLD=2'b01, DRAIN=2'b10.
  - Bubble constant `IF_BUBBLE`=32'h0.
  - Default `RESET_PC`.
- One natural sub-module, `if_id_pipeline_reg`: holds `INSTRUCTION`/`PC_OUT`/`PC_PLUS4`/`VALID` with flush/hold/load inputs and async active-low reset.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory returning addr^0xA5A5_0000, no stalls → IF/ID `PC_OUT` steps 0x100, 0x104, 0x108 on consecutive edges, with `PC_PLUS4`=`PC_OUT`+4.
- `STALL` high for 3 cycles while memory is ready → IF/ID frozen; exactly one word captured in skid; `IMEM_READ`=0 in HOLD. After release, the next IF/ID is the skid word and no address is skipped or repeated.
- Busywait of 4 cycles at 0x200, with `BRANCH_TAKEN` to 0x403 in the 2nd cycle → `IMEM_ADDR` stays 0x200 until accept; the 0x200 word is discarded; the next fetch is at 0x400; `VALID`=0 throughout.
- `BRANCH_TAKEN` and `STALL` in the same cycle in HOLD → skid dropped, `VALID`=0, next fetch at target.
- `pc`=0xFFFF_FFFC → next fetch address is 0x0000_0000.
- `RESET` pulsed low mid-busywait → all outputs return to reset values within the same cycle; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, bubble word, default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_t;

  localparam logic [31:0] IF_BUBBLE        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble is inserted.
module if_id_pipeline_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= IF_BUBBLE;
      pc_out      <= '0;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= IF_BUBBLE;
      valid       <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        instruction <= instr_in;
        pc_out      <= pc_in;
        pc_plus4    <= pc_in + 32'd4;
        valid       <= 1'b1;
      end else begin
        instruction <= IF_BUBBLE;
        valid       <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: owns the PC, reads a busywait instruction memory, absorbs decode
// stalls with a one-entry skid buffer and redirects on taken branches from EX.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTR,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4,
  output logic        VALID
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  redirect_pc;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;
  logic [31:0]  target;
  logic         accept;
  logic         ifid_load;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;

  assign target    = BRANCH_TARGET & ~32'h3;
  // Reset gating keeps the request low while RESET is held; otherwise only state drives it.
  assign IMEM_READ = RESET && (state != HOLD);
  assign IMEM_ADDR = pc;
  assign accept    = IMEM_READ && !IMEM_BUSYWAIT;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_instr = IMEM_INSTR;
    ifid_pc    = pc;
    case (state)
      FETCH: ifid_load = accept;
      HOLD: begin
        ifid_load  = 1'b1;
        ifid_instr = skid_instr;
        ifid_pc    = skid_pc;
      end
      default: ifid_load = 1'b0;
    endcase
  end

  // NOTE: the skid and redirect registers are reset as well, so no X can ever reach decode.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= '0;
      skid_instr  <= IF_BUBBLE;
      skid_pc     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            if (BRANCH_TAKEN) begin
              pc <= target;
            end else begin
              pc <= pc + 32'd4;
              if (STALL) begin
                skid_instr <= IMEM_INSTR;
                skid_pc    <= pc;
                state      <= HOLD;
              end
            end
          end else if (BRANCH_TAKEN) begin
            redirect_pc <= target;
            state       <= DRAIN;
          end
        end
        HOLD: begin
          if (BRANCH_TAKEN) begin
            pc    <= target;
            state <= FETCH;
          end else if (!STALL) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          // The in-flight read must complete; its word is thrown away.
          if (accept) begin
            pc    <= BRANCH_TAKEN ? target : redirect_pc;
            state <= FETCH;
          end else if (BRANCH_TAKEN) begin
            redirect_pc <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_pipeline_reg u_if_id (
    .clk         (CLK),
    .rst_n       (RESET),
    .flush       (BRANCH_TAKEN),
    .hold        (STALL),
    .load        (ifid_load),
    .instr_in    (ifid_instr),
    .pc_in       (ifid_pc),
    .instruction (INSTRUCTION),
    .pc_out      (PC_OUT),
    .pc_plus4    (PC_PLUS4),
    .valid       (VALID)
  );

endmodule
